mseq_calc_ctrl: RTL and testbench

MSEQ_CALC_CTRL -- requirements
Module: mseq_calc_ctrl

---
 rtl/mseq_calc_ctrl.sv | 128 ++++++++++++
 tb/tb_mseq_calc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mseq_calc_ctrl.sv
// Frame sequencer for an M-sequence datapath: loads the seed, steps the datapath once per word,
// and hands each word downstream with a valid/ready stream. Optional zero-seed guard: MSEQ_ZERO_GUARD_EN.
module mseq_calc_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  load,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  calcu_ctrl,
    input  logic [DATA_WIDTH-1:0] dp_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        WAIT,
        HOLD,
        DONE
    } state_t;

    state_t               state_reg;
    logic [CNT_WIDTH-1:0] len_reg;

    // Every output is registered and set on the transition into the state that owns it,
    // so strobes line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            load       <= 1'b0;
            load_data  <= '0;
            calcu_ctrl <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
        end else begin
            load       <= 1'b0;
            calcu_ctrl <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            if (state_reg != IDLE && abort) begin
                // word_cnt is left as-is so software can see how far the frame got
                state_reg <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            if (frame_len == '0) begin
                                err <= 1'b1;
                            end else begin
                                len_reg   <= frame_len;
                                word_cnt  <= '0;
                                state_reg <= LOAD;
                                busy      <= 1'b1;
                                load      <= 1'b1;
`ifdef MSEQ_ZERO_GUARD_EN
                                // an all-zero seed would lock the LFSR at zero forever
                                load_data <= (seed == '0) ? DATA_WIDTH'(1) : seed;
                                err       <= (seed == '0);
`else
                                load_data <= seed;
`endif
                            end
                        end
                    end
                    LOAD: begin
                        state_reg  <= STEP;
                        calcu_ctrl <= 1'b1;
                    end
                    STEP: begin
                        state_reg <= WAIT;
                    end
                    WAIT: begin
                        out_data  <= dp_data;
                        out_valid <= 1'b1;
                        out_last  <= (word_cnt == (len_reg - 1'b1));
                        state_reg <= HOLD;
                    end
                    HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            word_cnt  <= word_cnt + 1'b1;
                            if (out_last) begin
                                state_reg <= DONE;
                                done      <= 1'b1;
                            end else begin
                                state_reg  <= STEP;
                                calcu_ctrl <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mseq_calc_ctrl.sv
// Self-checking bench for mseq_calc_ctrl: vector table for IDLE decisions, hand-written corner
// sequences, and randomized frames checked against an LFSR word-sequence reference.
module tb_mseq_calc_ctrl;

    localparam int CW = 4;
    localparam int DW = 64;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] frame_len;
    logic [DW-1:0] seed;
    logic          load;
    logic [DW-1:0] load_data;
    logic          calcu_ctrl;
    logic [DW-1:0] dp_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] load_mask, calc_mask, hs_mask, done_mask;

    mseq_calc_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .frame_len(frame_len), .seed(seed), .load(load), .load_data(load_data),
        .calcu_ctrl(calcu_ctrl), .dp_data(dp_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
        return (x >> 1) ^ (x[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction

    // Stub datapath: reloads on load, advances one LFSR step per calcu_ctrl.
    always @(posedge clk) begin
        if (load) dp_data <= load_data;
        else if (calcu_ctrl) dp_data <= lfsr_next(dp_data);
    end

    function automatic logic [DW-1:0] guard_seed(input logic [DW-1:0] s);
`ifdef MSEQ_ZERO_GUARD_EN
        return (s == '0) ? 64'd1 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic exp_seed_err(input logic [DW-1:0] s);
`ifdef MSEQ_ZERO_GUARD_EN
        return (s == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {57'd0, load, calcu_ctrl, out_valid, out_last, busy, done, err}, 64'd0);
        check({tag, "_load_data"}, load_data, 64'd0);
        check({tag, "_out_data"}, out_data, 64'd0);
        check({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    // Runs one frame from IDLE; observation index 1 is the cycle after start is sampled.
    task automatic run_frame(input int len, input logic [DW-1:0] sd, input bit rnd_ready,
                             input int abort_cyc, input bit start_noise, output int hs);
        logic [DW-1:0] exp_w;
        int cyc;
        bit fin, aborted;
        int quiet_bad;
        exp_w = guard_seed(sd);
        hs = 0; cyc = 0; fin = 0; aborted = 0;
        load_mask = 0; calc_mask = 0; hs_mask = 0; done_mask = 0;
        frame_len = CW'(len); seed = sd; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        while (!fin && cyc < 2000) begin
            tick();
            cyc++;
            start = start_noise;
            if (start_noise) frame_len = CW'($urandom);
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc < 32) begin
                load_mask[cyc] = load;
                calc_mask[cyc] = calcu_ctrl;
                done_mask[cyc] = done;
            end
            if (cyc == 1) begin
                check("load_strobe", 64'(load), 64'd1);
                check("load_data", load_data, guard_seed(sd));
                check("start_err", 64'(err), 64'(exp_seed_err(sd)));
            end
            if (done) begin
                check("done_word_cnt", 64'(word_cnt), 64'(len));
                fin = 1;
            end else if (cyc == abort_cyc) begin
                abort = 1'b1; start = 1'b0;
                tick();
                abort = 1'b0;
                check("abort_out_valid", 64'(out_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_word_cnt", 64'(word_cnt), 64'(hs));
                aborted = 1; fin = 1;
            end else if (out_valid && out_ready) begin
                exp_w = lfsr_next(exp_w);
                check("out_data", out_data, exp_w);
                check("out_last", 64'(out_last), 64'(hs == len - 1));
                if (cyc < 32) hs_mask[cyc] = 1'b1;
                hs++;
            end
        end
        start = 1'b0; out_ready = 1'b1;
        check("frame_finished", 64'(fin), 64'd1);
        if (aborted) begin
            quiet_bad = 0;
            repeat (4) begin
                tick();
                if (done || busy || out_valid) quiet_bad++;
            end
            check("abort_quiet", 64'(quiet_bad), 64'd0);
        end else begin
            tick();
            check("hs_count", 64'(hs), 64'(len));
            check("idle_after_done", 64'(busy), 64'd0);
        end
    endtask

    typedef struct {
        bit          st;
        bit          ab;
        int          len;
        logic [63:0] sd;
        bit          exp_busy;
        bit          exp_err;
        bit          exp_load;
        logic [63:0] exp_ld;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, stall_bad, rhs;
        bit dn;
        logic [DW-1:0] held, ew;

        vecs[0] = '{0, 0, 3, 64'h55, 0, 0, 0, 64'h0};
        vecs[1] = '{1, 0, 0, 64'h55, 0, 1, 0, 64'h0};
        vecs[2] = '{1, 1, 3, 64'h55, 0, 0, 0, 64'h0};
        vecs[3] = '{1, 1, 0, 64'h55, 0, 0, 0, 64'h0};
        vecs[4] = '{1, 0, 5, 64'h1234, 1, 0, 1, 64'h1234};
        vecs[5] = '{1, 0, 1, 64'h0, 1, exp_seed_err(64'h0), 1, guard_seed(64'h0)};
        vecs[6] = '{1, 0, 15, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0; seed = '0; out_ready = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // IDLE decision table
        foreach (vecs[i]) begin
            start = vecs[i].st; abort = vecs[i].ab; frame_len = CW'(vecs[i].len); seed = vecs[i].sd;
            tick();
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_load", i), 64'(load), 64'(vecs[i].exp_load));
            if (vecs[i].exp_load) check($sformatf("vec%0d_load_data", i), load_data, vecs[i].exp_ld);
            start = 1'b0; abort = 1'b1;
            tick();
            abort = 1'b0;
            check($sformatf("vec%0d_busy_after", i), 64'(busy), 64'd0);
            check($sformatf("vec%0d_err_after", i), 64'(err), 64'd0);
        end

        // Reference frame: timing of every strobe against the start cycle
        run_frame(4, 64'hACE1, 0, -1, 0, hs);
        check("ref_load_cycles", 64'(load_mask), 64'h2);
        check("ref_calc_cycles", 64'(calc_mask), 64'h924);
        check("ref_hs_cycles", 64'(hs_mask), 64'h2490);
        check("ref_done_cycles", 64'(done_mask), 64'h4000);

        // Backpressure: 10 stalled cycles in HOLD
        frame_len = CW'(3); seed = 64'h0BAD_F00D; out_ready = 1'b0; start = 1'b1;
        dn = 0;
        for (int i = 0; i < 10 && !dn; i++) begin
            tick();
            start = 1'b0;
            dn = out_valid;
        end
        check("stall_reached_hold", 64'(dn), 64'd1);
        held = out_data;
        check("stall_first_word", held, lfsr_next(64'h0BAD_F00D));
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_data !== held || calcu_ctrl) stall_bad++;
        end
        check("stall_stable", 64'(stall_bad), 64'd0);
        out_ready = 1'b1;
        rhs = 0; dn = 0;
        for (int i = 0; i < 30 && !dn; i++) begin
            if (out_valid) rhs++;
            if (done) dn = 1;
            else tick();
        end
        check("stall_resume_words", 64'(rhs), 64'd3);
        check("stall_resume_done", 64'(dn), 64'd1);
        tick();

        // Abort in the second HOLD of an 8-word frame
        run_frame(8, 64'h1357_9BDF, 0, 7, 0, hs);
        check("abort2_hs", 64'(hs), 64'd1);

        // Start held high throughout a busy frame must not disturb it
        run_frame(2, 64'hC0FFEE, 0, -1, 1, hs);

        // Full-length frame at the counter limit
        run_frame(15, 64'h8000_0000_0000_0001, 0, -1, 0, hs);

        // Zero seed through a whole frame
        run_frame(3, 64'h0, 1, -1, 0, hs);

        // Asynchronous reset in the middle of STEP
        frame_len = CW'(3); seed = 64'h77; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_in_step", 64'(calcu_ctrl), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(2, 64'h2468_ACE0, 0, -1, 0, hs);
        ew = lfsr_next(64'h2468_ACE0);
        check("post_reset_data_model", ew, lfsr_next(64'h2468_ACE0) & 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            int rl, ac;
            logic [DW-1:0] rs;
            rl = int'($urandom_range(1, 7));
            rs = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rs = '0;
            ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : -1;
            run_frame(rl, rs, 1, ac, 1'($urandom_range(0, 1)), hs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
